// File: rtl/clock_logic_pkg.sv
// Shared types and defaults for the clock-logic handshake crossing controllers.
package clock_logic_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_VALID,
    HS_ACK
  } hs_rx_state_t;

  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/clock_logic_sync_bit.sv
// Reset-clearable multi-flop synchronizer for a single control bit.
// CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN clocks the first stage on the falling edge.
module clock_logic_sync_bit
  import clock_logic_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic                   first_q;
  logic [SYNC_STAGES-2:0] rest_q;
  logic [SYNC_STAGES-1:0] chain;

`ifdef CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN
  // Half-cycle head start: the falling-edge stage shortens req_s latency by half a period.
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) first_q <= 1'b0;
    else         first_q <= d;
  end
`else
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) first_q <= 1'b0;
    else         first_q <= d;
  end
`endif

  assign chain = {rest_q, first_q};

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rest_q <= '0;
    else         rest_q <= chain[SYNC_STAGES-2:0];
  end

  assign q = rest_q[SYNC_STAGES-2];

endmodule

// File: rtl/clock_logic_cross_handshake_rx.sv
// Receive side of a 4-phase req/ack bus crossing with a valid/ready local output.
// Build option: CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN (falling-edge first sync stage).
module clock_logic_cross_handshake_rx
  import clock_logic_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 async_req,
  input  logic [WIDTH-1:0]     async_data,
  output logic                 async_ack,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  hs_rx_state_t         state_q;
  logic                 ack_q;
  logic                 valid_q;
  logic [WIDTH-1:0]     data_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 req_s;

  clock_logic_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clock (clock),
    .resetn(resetn),
    .d     (async_req),
    .q     (req_s)
  );

  // async_data is sampled only in IDLE with req_s high, when the sender guarantees it is stable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= HS_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        HS_IDLE: begin
          if (req_s) begin
            data_q  <= async_data;
            valid_q <= 1'b1;
            state_q <= HS_VALID;
          end
        end
        HS_VALID: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            count_q <= count_q + CNT_WIDTH'(1);
            state_q <= HS_ACK;
          end
        end
        HS_ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= HS_IDLE;
          end
        end
        default: state_q <= HS_IDLE;
      endcase
    end
  end

  assign async_ack  = ack_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign busy       = (state_q != HS_IDLE);
  assign xfer_count = count_q;

endmodule

// File: tb/tb_clock_logic_cross_handshake_rx.sv
// Self-checking bench: a delay-line/flag protocol model compared against the DUT on every cycle.
module tb_clock_logic_cross_handshake_rx;

  localparam int W  = 8;
  localparam int SS = 2;
`ifdef CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN
  localparam int LAT = SS - 1;
`else
  localparam int LAT = SS;
`endif

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         async_req = 1'b0;
  logic [W-1:0] async_data = '0;
  logic         out_ready = 1'b0;

  logic         async_ack, out_valid, busy;
  logic [W-1:0] out_data;
  logic [15:0]  xfer_count;
  logic         ack_w, valid_w, busy_w;
  logic [W-1:0] data_w;
  logic [3:0]   count_w;

  clock_logic_cross_handshake_rx #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(16)) dut (
    .clock(clock), .resetn(resetn), .async_req(async_req), .async_data(async_data),
    .async_ack(async_ack), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .xfer_count(xfer_count)
  );

  clock_logic_cross_handshake_rx #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_WIDTH(4)) dut_w (
    .clock(clock), .resetn(resetn), .async_req(async_req), .async_data(async_data),
    .async_ack(ack_w), .out_valid(valid_w), .out_data(data_w),
    .out_ready(out_ready), .busy(busy_w), .xfer_count(count_w)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol model: the FSM sees async_req delayed by LAT edges; the word is held until
  // accepted, then ack stays up until the delayed request is seen low.
  bit           m_hold, m_ack;
  logic [W-1:0] m_data;
  int unsigned  m_cnt;
  bit           hist [8];
  logic [W-1:0] exp_q [$];
  logic         last_v;
  logic [W-1:0] last_d;

  always begin
    @(posedge clock);
    if (!resetn) begin
      m_hold = 0; m_ack = 0; m_data = '0; m_cnt = 0; last_v = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
    end else begin
      bit seen;
      seen = hist[LAT-1];
      if (last_v && out_ready) begin
        if (exp_q.size() == 0) check("accept_extra", {24'd0, last_d}, 32'hFFFF_FFFF);
        else                   check("accept_word", {24'd0, last_d}, {24'd0, exp_q.pop_front()});
      end
      if (m_hold) begin
        if (out_ready) begin m_hold = 0; m_ack = 1; m_cnt++; end
      end else if (m_ack) begin
        if (!seen) m_ack = 0;
      end else if (seen) begin
        m_hold = 1; m_data = async_data;
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = async_req;
    end
    #1;
    check("cyc_valid", {31'd0, out_valid}, {31'd0, m_hold});
    check("cyc_data",  {24'd0, out_data},  {24'd0, m_data});
    check("cyc_ack",   {31'd0, async_ack}, {31'd0, m_ack});
    check("cyc_busy",  {31'd0, busy},      {31'd0, m_hold | m_ack});
    check("cyc_count", {16'd0, xfer_count}, m_cnt % 65536);
    check("cyc_w_valid", {31'd0, valid_w}, {31'd0, m_hold});
    check("cyc_w_ack",   {31'd0, ack_w},   {31'd0, m_ack});
    check("cyc_w_data",  {24'd0, data_w},  {24'd0, m_data});
    check("cyc_w_count", {28'd0, count_w}, m_cnt % 16);
    last_v = out_valid;
    last_d = out_data;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Wait (sampling at +1 after each edge) until valid (sel=0) or ack (sel=1) equals level.
  task automatic wait_sig(input string name, input bit sel, input bit level,
                          input bit rnd_ready, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end while (((sel ? async_ack : out_valid) != level) && n < 200);
    if (n >= 200) check(name, 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int n;
    async_data = d;
    async_req  = 1'b1;
    exp_q.push_back(d);
    wait_sig("timeout_ack_rise", 1'b1, 1'b1, 1'b1, n);
    #1;
    async_req  = 1'b0;
    async_data = W'($urandom);
    wait_sig("timeout_ack_fall", 1'b1, 1'b0, 1'b1, n);
    tick();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_ack",   {31'd0, async_ack}, 0);
    check("rst_data",  {24'd0, out_data},  0);
    check("rst_busy",  {31'd0, busy},      0);
    check("rst_count", {16'd0, xfer_count}, 0);
    #1 resetn = 1'b1;
    tick();

    // Single transfer with literal latencies.
    async_data = 8'hA5;
    out_ready  = 1'b1;
    async_req  = 1'b1;
    exp_q.push_back(8'hA5);
    wait_sig("timeout_t1_valid", 1'b0, 1'b1, 1'b0, n);
    check("t1_valid_latency", n, LAT + 1);
    check("t1_data", {24'd0, out_data}, 32'hA5);
    check("t1_ack_early", {31'd0, async_ack}, 0);
    @(posedge clock); #1;
    check("t1_ack_rise", {31'd0, async_ack}, 1);
    check("t1_count", {16'd0, xfer_count}, 1);
    #1 async_req = 1'b0;
    wait_sig("timeout_t1_ackfall", 1'b1, 1'b0, 1'b0, n);
    check("t1_ack_fall_latency", n, LAT + 1);
    tick();

    // Backpressure: word held, ack withheld.
    out_ready  = 1'b0;
    async_data = 8'hA5;
    async_req  = 1'b1;
    exp_q.push_back(8'hA5);
    wait_sig("timeout_bp_valid", 1'b0, 1'b1, 1'b0, n);
    repeat (20) begin @(posedge clock); #1; end
    check("bp_valid", {31'd0, out_valid}, 1);
    check("bp_data",  {24'd0, out_data},  32'hA5);
    check("bp_ack",   {31'd0, async_ack}, 0);
    check("bp_busy",  {31'd0, busy},      1);
    #1 out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_ack_rise", {31'd0, async_ack}, 1);
    #1 async_req = 1'b0;
    wait_sig("timeout_bp_ackfall", 1'b1, 1'b0, 1'b0, n);
    tick();

    // Data isolation while req is low.
    repeat (30) begin
      tick();
      async_data = W'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    check("iso_valid", {31'd0, out_valid}, 0);
    check("iso_data",  {24'd0, out_data},  32'hA5);
    tick();

    // Back-to-back words 0x01..0x10 under random ready.
    for (int i = 1; i <= 16; i++) send_word(W'(i));
    @(posedge clock); #1;
    check("b2b_count", {16'd0, xfer_count}, 18);
    check("b2b_drained", exp_q.size(), 0);
    tick();

    // Reset while holding a word in VALID.
    out_ready  = 1'b0;
    async_data = 8'h3C;
    async_req  = 1'b1;
    wait_sig("timeout_rv_valid", 1'b0, 1'b1, 1'b0, n);
    #1 resetn = 1'b0;
    #1;
    check("rv_valid", {31'd0, out_valid}, 0);
    check("rv_ack",   {31'd0, async_ack}, 0);
    check("rv_data",  {24'd0, out_data},  0);
    check("rv_busy",  {31'd0, busy},      0);
    check("rv_count", {16'd0, xfer_count}, 0);
    async_req = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Reset while in ACK.
    out_ready  = 1'b1;
    async_data = 8'h5A;
    async_req  = 1'b1;
    exp_q.push_back(8'h5A);
    wait_sig("timeout_ra_ack", 1'b1, 1'b1, 1'b0, n);
    #1 resetn = 1'b0;
    #1;
    check("ra_ack",   {31'd0, async_ack}, 0);
    check("ra_valid", {31'd0, out_valid}, 0);
    check("ra_busy",  {31'd0, busy},      0);
    check("ra_count", {16'd0, xfer_count}, 0);
    async_req = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    // 17 fresh transfers: wide counter reads 17, 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) send_word(W'($urandom));
    @(posedge clock); #1;
    check("wrap_count16", {16'd0, xfer_count}, 17);
    check("wrap_count4",  {28'd0, count_w},    1);
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_logic_cross_handshake_rx.md
Name: clock_logic_cross_handshake_rx

Overview:
- Receive-side controller for a 4-phase req/ack crossing of a WIDTH-bit bus into the local clock domain.
- Sequences the bit synchronizer on the incoming request, captures the bus only while the protocol guarantees it is stable, and returns the acknowledge.
- Presents each word to a local consumer through a valid/ready handshake.
- Sits at the destination edge of every multi-bit clock-domain crossing in the logistic/clock area.

Parameters:
- WIDTH, 8: data bus width in bits (>=1).
- SYNC_STAGES, 2: synchronizer depth on async_req (>=2).
- CNT_WIDTH, 16: width of the transfer counter.

Ports:
- clock  input  1  local domain clock.
- resetn  input  1  asynchronous active-low reset.
- async_req  input  1  request from the foreign domain, unsynchronized.
- async_data  input  WIDTH  foreign data; held stable by the sender while async_req=1.
- async_ack  output  1  acknowledge to the foreign domain, driven straight from a flop.
- out_valid  output  1  captured word available.
- out_data  output  WIDTH  captured word.
- out_ready  input  1  consumer accepts the word when out_valid&out_ready.
- busy  output  1  1 whenever state != IDLE.
- xfer_count  output  CNT_WIDTH  completed transfers.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low on resetn. All flops clear on reset.
- Reset values: async_ack=0, out_valid=0, out_data=0, busy=0, xfer_count=0, state=IDLE, sync chain=0.
- req_s is async_req after SYNC_STAGES flops. req_s is the only signal the FSM reads from the foreign domain. async_data is never used except at capture.
- FSM, IDLE:
  - If req_s=1: out_data<=async_data, out_valid<=1, go VALID.
  - The word is visible the cycle after req_s is first seen high.
- FSM, VALID:
  - Hold out_valid=1 and keep out_data stable.
  - On out_valid&out_ready: out_valid<=0, async_ack<=1, xfer_count<=xfer_count+1 (wraps modulo 2^CNT_WIDTH), go ACK.
- FSM, ACK:
  - Hold async_ack=1.
  - If req_s=0: async_ack<=0, go IDLE.
  - A new request is not sampled until after IDLE is re-entered, so there is at least one IDLE cycle between words.
- Backpressure: with out_ready=0 the block stays in VALID indefinitely. The ack is withheld, which stalls the sender.
- Latency with default stages: async_req rising before edge k gives req_s=1 at edge k+1 and out_valid=1 at edge k+2. Ready in the same cycle gives async_ack=1 at the next edge.
- Glitches: a req pulse shorter than one period may be missed. That is legal because the protocol forbids it. req_s dropping while in VALID is a protocol error and is ignored; the FSM still completes through ACK.
- Reset mid-operation: async_ack and out_valid drop immediately and the pending word is discarded. The sender must restart its handshake from req=0.
- Throughput: one word per 2*SYNC_STAGES+3 cycles minimum, plus the sender's synchronization delay.

Optional Feature:
- Macro: CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN.
- Defined: the first sync stage is clocked on ~clock (falling edge) and the remaining stages on clock. req_s latency drops by half a cycle, so default-stage out_valid rises at edge k+1 for a rise more than half a period before edge k.
- Undefined: all stages are on the rising edge, with the latency stated above.
- The FSM, counter and outputs are identical in both builds.

Decomposition:
- Package clock_logic_pkg:
  - typedef enum logic [1:0] {HS_IDLE, HS_VALID, HS_ACK} hs_rx_state_t.
  - localparam default SYNC_STAGES=2.
- Sub-module clock_logic_sync_bit: SYNC_STAGES-deep dffr chain with resetn. It honours CLOCK_LOGIC_CROSS_HANDSHAKE_NEGEDGE_FIRST_EN for its first stage and is reusable by the matching tx controller.

Test Plan:
- Single transfer: data=8'hA5, req=1, out_ready=1 held → out_valid at req rise +2 edges with out_data=A5. async_ack=1 one cycle later. Drop req → ack=0 after 2 edges. xfer_count=1.
- Backpressure: out_ready=0 for 20 cycles → out_valid stays 1, out_data=A5, async_ack=0, busy=1. Raise ready → ack rises next edge.
- Back-to-back: sender model sends 8'h01..8'h10 with full handshakes → 16 words in order, no duplicates, xfer_count=16.
- Data isolation: async_data toggles randomly while req=0 → out_data and out_valid unaffected.
- Mid-op reset: pull resetn low in VALID and again in ACK → all outputs 0 within the reset cycle. The next handshake after release completes normally.
- Counter wrap with CNT_WIDTH=4: 17 transfers → xfer_count=1. The NEGEDGE_FIRST_EN build shows out_valid half a cycle earlier.
